// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALU-op and forwarding-select encodings plus the control bundle type.
// Pure definitions: no latency and no flow control.
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/hazard_fwd_unit.sv
// RAW hazard stall and EX forwarding selects; purely combinational (0 cycles).
// Stall is the backpressure: it is asserted to the caller, which holds PC and IF/ID.
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW     = 3,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              uses_rs_id,
  input  logic              uses_rt_id,
  input  logic              flush_id,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dest,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  logic ex_writes, mem_writes, wb_writes;
  logic ex_hits, mem_hits, load_use;

  assign ex_writes  = ex_reg_write  && (ex_dest  != '0);
  assign mem_writes = mem_reg_write && (mem_dest != '0);
  assign wb_writes  = wb_reg_write  && (wb_dest  != '0);

  assign ex_hits  = ex_writes  && ((uses_rs_id && ex_dest == rs_id)  || (uses_rt_id && ex_dest == rt_id));
  assign mem_hits = mem_writes && ((uses_rs_id && mem_dest == rs_id) || (uses_rt_id && mem_dest == rt_id));

  // A load's data exists only after MEM, so one bubble is unavoidable even with forwarding.
  assign load_use = ex_mem_read && (ex_dest != '0) &&
                    ((ex_dest == rs_id) || (uses_rt_id && ex_dest == rt_id));

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic m_wr, input logic [REG_AW-1:0] m_dest,
                                         input logic w_wr, input logic [REG_AW-1:0] w_dest);
    if (!ENABLE_FWD || src == '0) return FWD_RF;
    if (m_wr && m_dest == src)    return FWD_MEM;
    if (w_wr && w_dest == src)    return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    stall = 1'b0;
    if (!flush_id) stall = ENABLE_FWD ? load_use : (ex_hits || mem_hits);
    fwd_a = fwd_sel(ex_rs, mem_writes, mem_dest, wb_writes, wb_dest);
    fwd_b = fwd_sel(ex_rt, mem_writes, mem_dest, wb_writes, wb_dest);
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipeline control path: decode, ID/EX-EX/MEM-MEM/WB control registers (EX +1, MEM +2, WB +3 cycles).
// Backpressure: a hazard stall drops pc_write/ifid_write and injects a bubble into ID/EX.
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OPC_W      = 4,
  parameter int REG_AW     = 3,
  parameter int ALU_OP_W   = 2,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPC_W-1:0]    opcode_id,
  input  logic [REG_AW-1:0]   rs_id,
  input  logic [REG_AW-1:0]   rt_id,
  input  logic [REG_AW-1:0]   rd_id,
  input  logic                flush_id,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                stall,
  output logic                reg_dst_ex,
  output logic                alu_src_ex,
  output logic [ALU_OP_W-1:0] alu_op_ex,
  output logic [1:0]          fwd_a_ex,
  output logic [1:0]          fwd_b_ex,
  output logic                mem_read_mem,
  output logic                mem_write_mem,
  output logic [REG_AW-1:0]   wr_addr_mem,
  output logic                reg_write_wb,
  output logic                mem_to_reg_wb,
  output logic [REG_AW-1:0]   wr_addr_wb
);

  localparam ctrl_t BUBBLE = ctrl_t'({CTRL_W{1'b0}});

  ctrl_t             id_ctrl, ex_ctrl;
  logic              uses_rs_id, uses_rt_id;
  logic [REG_AW-1:0] dest_id, ex_dest, ex_rs, ex_rt;
  logic              mem_reg_write, mem_mem_to_reg;
  logic              wb_reg_write, wb_mem_to_reg;
  logic [REG_AW-1:0] mem_dest, wb_dest;
  logic              run;

  always_comb begin
    id_ctrl    = BUBBLE;
    uses_rs_id = 1'b0;
    uses_rt_id = 1'b0;
    // Any set bit above the 4-bit opcode field decodes as a NOP.
    if ((opcode_id >> 4) == '0) begin
      case (opcode_id[3:0])
        OP_R: begin
          id_ctrl.reg_dst   = 1'b1;
          id_ctrl.reg_write = 1'b1;
          id_ctrl.alu_op    = ALU_FUNCT;
          uses_rs_id        = 1'b1;
          uses_rt_id        = 1'b1;
        end
        OP_ADDI: begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.reg_write = 1'b1;
          id_ctrl.alu_op    = ALU_ADD;
          uses_rs_id        = 1'b1;
        end
        OP_LW: begin
          id_ctrl.alu_src    = 1'b1;
          id_ctrl.mem_read   = 1'b1;
          id_ctrl.mem_to_reg = 1'b1;
          id_ctrl.reg_write  = 1'b1;
          uses_rs_id         = 1'b1;
        end
        OP_SW: begin
          id_ctrl.alu_src   = 1'b1;
          id_ctrl.mem_write = 1'b1;
          uses_rs_id        = 1'b1;
          uses_rt_id        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dest_id = id_ctrl.reg_dst ? rd_id : rt_id;

  hazard_fwd_unit #(
    .REG_AW     (REG_AW),
    .ENABLE_FWD (ENABLE_FWD)
  ) u_hazard (
    .rs_id         (rs_id),
    .rt_id         (rt_id),
    .uses_rs_id    (uses_rs_id),
    .uses_rt_id    (uses_rt_id),
    .flush_id      (flush_id),
    .ex_mem_read   (ex_ctrl.mem_read),
    .ex_reg_write  (ex_ctrl.reg_write),
    .ex_dest       (ex_dest),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .mem_reg_write (mem_reg_write),
    .mem_dest      (mem_dest),
    .wb_reg_write  (wb_reg_write),
    .wb_dest       (wb_dest),
    .stall         (stall),
    .fwd_a         (fwd_a_ex),
    .fwd_b         (fwd_b_ex)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run            <= 1'b0;
      ex_ctrl        <= BUBBLE;
      ex_dest        <= '0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      mem_read_mem   <= 1'b0;
      mem_write_mem  <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_dest       <= '0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_dest        <= '0;
    end else begin
      run <= 1'b1;
      if (stall || flush_id) begin
        ex_ctrl <= BUBBLE;
        ex_dest <= '0;
        ex_rs   <= '0;
        ex_rt   <= '0;
      end else begin
        ex_ctrl <= id_ctrl;
        ex_dest <= dest_id;
        ex_rs   <= rs_id;
        ex_rt   <= rt_id;
      end
      mem_read_mem   <= ex_ctrl.mem_read;
      mem_write_mem  <= ex_ctrl.mem_write;
      mem_reg_write  <= ex_ctrl.reg_write;
      mem_mem_to_reg <= ex_ctrl.mem_to_reg;
      mem_dest       <= ex_dest;
      wb_reg_write   <= mem_reg_write;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_dest        <= mem_dest;
    end
  end

  assign pc_write      = run && !stall;
  assign ifid_write    = run && !stall;
  assign reg_dst_ex    = ex_ctrl.reg_dst;
  assign alu_src_ex    = ex_ctrl.alu_src;
  assign alu_op_ex     = ALU_OP_W'(ex_ctrl.alu_op);
  assign wr_addr_mem   = mem_dest;
  assign reg_write_wb  = wb_reg_write;
  assign mem_to_reg_wb = wb_mem_to_reg;
  assign wr_addr_wb    = wb_dest;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Drives one instruction stream into a forwarding and a non-forwarding instance and
// compares both against an instruction-level pipeline model every cycle.
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode_id;
  logic [2:0] rs_id, rt_id, rd_id;
  logic       flush_id;

  // index 0: ENABLE_FWD=1, index 1: ENABLE_FWD=0
  logic       pc_write[2], ifid_write[2], stall[2], reg_dst_ex[2], alu_src_ex[2];
  logic [1:0] alu_op_ex[2], fwd_a_ex[2], fwd_b_ex[2];
  logic       mem_read_mem[2], mem_write_mem[2], reg_write_wb[2], mem_to_reg_wb[2];
  logic [2:0] wr_addr_mem[2], wr_addr_wb[2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_control_unit #(.OPC_W(4), .REG_AW(3), .ALU_OP_W(2), .ENABLE_FWD(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .flush_id(flush_id), .pc_write(pc_write[0]), .ifid_write(ifid_write[0]), .stall(stall[0]),
    .reg_dst_ex(reg_dst_ex[0]), .alu_src_ex(alu_src_ex[0]), .alu_op_ex(alu_op_ex[0]),
    .fwd_a_ex(fwd_a_ex[0]), .fwd_b_ex(fwd_b_ex[0]), .mem_read_mem(mem_read_mem[0]),
    .mem_write_mem(mem_write_mem[0]), .wr_addr_mem(wr_addr_mem[0]),
    .reg_write_wb(reg_write_wb[0]), .mem_to_reg_wb(mem_to_reg_wb[0]), .wr_addr_wb(wr_addr_wb[0])
  );

  pipe_control_unit #(.OPC_W(4), .REG_AW(3), .ALU_OP_W(2), .ENABLE_FWD(1'b0)) u_nofwd (
    .clk(clk), .rst(rst), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .flush_id(flush_id), .pc_write(pc_write[1]), .ifid_write(ifid_write[1]), .stall(stall[1]),
    .reg_dst_ex(reg_dst_ex[1]), .alu_src_ex(alu_src_ex[1]), .alu_op_ex(alu_op_ex[1]),
    .fwd_a_ex(fwd_a_ex[1]), .fwd_b_ex(fwd_b_ex[1]), .mem_read_mem(mem_read_mem[1]),
    .mem_write_mem(mem_write_mem[1]), .wr_addr_mem(wr_addr_mem[1]),
    .reg_write_wb(reg_write_wb[1]), .mem_to_reg_wb(mem_to_reg_wb[1]), .wr_addr_wb(wr_addr_wb[1])
  );

  // One in-flight instruction as the model sees it.
  typedef struct packed {
    logic       reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
    logic [1:0] alu_op;
    logic [2:0] dest, rs, rt;
  } minst_t;

  minst_t m_ex[2], m_mem[2], m_wb[2];
  bit     m_run;

  function automatic minst_t mdec(logic [3:0] op, logic [2:0] rs, logic [2:0] rt, logic [2:0] rd);
    minst_t m = '0;
    case (op)
      4'b0000: begin m.reg_dst = 1; m.reg_write = 1; m.alu_op = 2'b10; end
      4'b0100: begin m.alu_src = 1; m.reg_write = 1; end
      4'b1000: begin m.alu_src = 1; m.mem_read = 1; m.mem_to_reg = 1; m.reg_write = 1; end
      4'b1010: begin m.alu_src = 1; m.mem_write = 1; end
      default: ;
    endcase
    m.rs = rs;
    m.rt = rt;
    m.dest = m.reg_dst ? rd : rt;
    return m;
  endfunction

  function automatic bit writes(minst_t m);
    return m.reg_write && m.dest != 0;
  endfunction

  function automatic bit reads(minst_t m);
    bit ur = (opcode_id == 0) || (opcode_id == 4) || (opcode_id == 8) || (opcode_id == 10);
    bit ut = (opcode_id == 0) || (opcode_id == 10);
    return writes(m) && ((ur && m.dest == rs_id) || (ut && m.dest == rt_id));
  endfunction

  function automatic bit exp_stall(int c);
    bit ut = (opcode_id == 0) || (opcode_id == 10);
    if (flush_id) return 0;
    if (c == 0)
      return m_ex[0].mem_read && m_ex[0].dest != 0 &&
             (m_ex[0].dest == rs_id || (ut && m_ex[0].dest == rt_id));
    return reads(m_ex[1]) || reads(m_mem[1]);
  endfunction

  function automatic logic [1:0] fsel(int c, logic [2:0] src);
    if (c == 1 || src == 0) return 2'b00;
    if (writes(m_mem[c]) && m_mem[c].dest == src) return 2'b10;
    if (writes(m_wb[c]) && m_wb[c].dest == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      bit s  = exp_stall(c);
      bit en = m_run && !s;
      chk($sformatf("ctl%0d", c), 16'({stall[c], pc_write[c], ifid_write[c]}), 16'({s, en, en}));
      chk($sformatf("ex%0d", c), 16'({reg_dst_ex[c], alu_src_ex[c], alu_op_ex[c]}),
          16'({m_ex[c].reg_dst, m_ex[c].alu_src, m_ex[c].alu_op}));
      chk($sformatf("fwd%0d", c), 16'({fwd_a_ex[c], fwd_b_ex[c]}),
          16'({fsel(c, m_ex[c].rs), fsel(c, m_ex[c].rt)}));
      chk($sformatf("mem%0d", c), 16'({mem_read_mem[c], mem_write_mem[c], wr_addr_mem[c]}),
          16'({m_mem[c].mem_read, m_mem[c].mem_write, m_mem[c].dest}));
      chk($sformatf("wb%0d", c), 16'({reg_write_wb[c], mem_to_reg_wb[c], wr_addr_wb[c]}),
          16'({m_wb[c].reg_write, m_wb[c].mem_to_reg, m_wb[c].dest}));
    end
  endtask

  task automatic drive(logic [3:0] op, logic [2:0] rs, logic [2:0] rt, logic [2:0] rd, logic fl);
    opcode_id = op; rs_id = rs; rt_id = rt; rd_id = rd; flush_id = fl;
    #2;
    check_all();
  endtask

  task automatic tick();
    bit s[2];
    for (int c = 0; c < 2; c++) s[c] = exp_stall(c);
    @(posedge clk);
    if (!rst) begin
      m_run = 1;
      for (int c = 0; c < 2; c++) begin
        m_wb[c]  = m_mem[c];
        m_mem[c] = m_ex[c];
        m_ex[c]  = (s[c] || flush_id) ? '0 : mdec(opcode_id, rs_id, rt_id, rd_id);
      end
    end
    #1;
  endtask

  task automatic step(logic [3:0] op, logic [2:0] rs, logic [2:0] rt, logic [2:0] rd, logic fl);
    drive(op, rs, rt, rd, fl);
    tick();
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b1;
    #1;
    m_run = 0;
    for (int c = 0; c < 2; c++) begin m_ex[c] = '0; m_mem[c] = '0; m_wb[c] = '0; end
    check_all();
    repeat (cycles) begin tick(); check_all(); end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    opcode_id = 4'b0000; rs_id = 0; rt_id = 0; rd_id = 0; flush_id = 0;
    #1;
    do_reset(3);
    chk("rst_pc_write", 16'(pc_write[0]), 16'd0);
    tick();
    drive(4'hF, 0, 0, 0, 0);
    chk("pc_write_after_rst", 16'(pc_write[0]), 16'd1);
    tick();

    // R(rd=3) then R(rs=3): EX/MEM forward
    step(4'b0000, 1, 2, 3, 0);
    step(4'b0000, 3, 1, 5, 0);
    drive(4'hF, 0, 0, 0, 0);
    chk("fwd_a_exmem", 16'(fwd_a_ex[0]), 16'b10);
    chk("no_stall_alu", 16'(stall[0]), 16'd0);
    tick();

    // One gap later: MEM/WB forward
    step(4'b0000, 1, 2, 3, 0);
    step(4'hF, 0, 0, 0, 0);
    step(4'b0000, 3, 1, 5, 0);
    drive(4'hF, 0, 0, 0, 0);
    chk("fwd_a_memwb", 16'(fwd_a_ex[0]), 16'b01);
    tick();

    // Load-use: one stall, bubble, then MEM/WB forward on B
    step(4'b1000, 1, 2, 0, 0);
    drive(4'b0000, 1, 2, 4, 0);
    chk("lu_stall", 16'({stall[0], pc_write[0], ifid_write[0]}), 16'b100);
    tick();
    drive(4'b0000, 1, 2, 4, 0);
    chk("lu_release", 16'(stall[0]), 16'd0);
    chk("lu_bubble", 16'({reg_dst_ex[0], alu_src_ex[0], alu_op_ex[0]}), 16'd0);
    tick();
    drive(4'hF, 0, 0, 0, 0);
    chk("lu_fwd", 16'({fwd_a_ex[0], fwd_b_ex[0]}), 16'b0001);
    tick();

    // Flush of the dependent instruction overrides the stall
    step(4'b1000, 1, 2, 0, 0);
    drive(4'b0000, 1, 2, 4, 1);
    chk("flush_stall", 16'({stall[0], pc_write[0]}), 16'b01);
    tick();
    drive(4'hF, 0, 0, 0, 0);
    chk("flush_bubble", 16'({reg_dst_ex[0], alu_src_ex[0], alu_op_ex[0]}), 16'd0);
    tick();

    // r0 never forwards or stalls; opcode 1111 is a NOP
    step(4'b0000, 1, 1, 0, 0);
    step(4'b0000, 0, 0, 5, 0);
    drive(4'b1111, 2, 3, 4, 0);
    chk("r0_fwd", 16'({fwd_a_ex[0], fwd_b_ex[0], stall[0]}), 16'd0);
    tick();
    drive(4'hF, 0, 0, 0, 0);
    chk("nop_bundle", 16'({reg_dst_ex[0], alu_src_ex[0], alu_op_ex[0]}), 16'd0);
    tick();

    // No forwarding: ADDI(rt=4) then SW(rt=4) stalls two cycles
    repeat (3) step(4'hF, 0, 0, 0, 0);
    step(4'b0100, 1, 4, 0, 0);
    drive(4'b1010, 1, 4, 0, 0);
    chk("nf_stall1", 16'({stall[1], fwd_a_ex[1], fwd_b_ex[1]}), 16'b10000);
    tick();
    drive(4'b1010, 1, 4, 0, 0);
    chk("nf_stall2", 16'(stall[1]), 16'd1);
    tick();
    drive(4'b1010, 1, 4, 0, 0);
    chk("nf_release", 16'(stall[1]), 16'd0);
    tick();

    // Randomized stream with one asynchronous reset mid-way
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 4))
        0: op = 4'b0000;
        1: op = 4'b0100;
        2: op = 4'b1000;
        3: op = 4'b1010;
        default: op = 4'($urandom_range(0, 15));
      endcase
      if (i == 200) begin
        do_reset(1);
        tick();
      end
      step(op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
